sum_bcd_display: RTL
====================

# sum_bcd_display

Downstream display stage for the 4-bit adder with carry-out (`sum4bcc`). It samples the 5-bit result {co, zi} (0..31) on a load strobe and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) FSM. It then drives a two-digit multiplexed 7-segment display, so lab boards can show the adder output in decimal.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays lit before the scan toggles (legal range ≥ 2)
- COMMON_ANODE, 1, 1 = active-low `sseg` and `an`; 0 = both active-high (bitwise inversion of all values below)

- clk    input   1   system clock, rising edge
- rst    input   1   asynchronous, active-high reset
- load   input   1   sample strobe; {co, zi} captured when load=1 in IDLE
- co     input   1   adder carry-out (MSB of the value)
- zi     input   4   adder sum (LSBs of the value)
- busy   output  1   high while a conversion is in progress
- tens   output  2   latched BCD tens digit (0..3)
- units  output  4   latched BCD units digit (0..9)
- sseg   output  7   segments {g,f,e,d,c,b,a}
- an     output  2   digit enables; an[0] = units, an[1] = tens

## Operation
- FSM states: IDLE, SHIFT, LATCH.
  - IDLE: if load=1, capture bin={co,zi}, clear bcd (6 bits) and shift count, go to SHIFT.
  - SHIFT: runs exactly 5 cycles. Each cycle, first add 3 to the units nibble if it is ≥ 5; the tens nibble never needs adjusting. Then shift {bcd, bin} left by 1. After the 5th shift, go to LATCH.
  - LATCH: copy bcd into `tens`/`units`, go to IDLE.
- load is ignored in SHIFT and LATCH. There is no queueing, and the value held in those states is never disturbed.
- `busy` = 1 in SHIFT and LATCH, 0 in IDLE.
- Result rule: units = value mod 10, tens = value div 10. Example: 31 → 3/1, 16 → 1/6.
- Display scan:
  - Counter runs 0..SCAN_DIV-1; on wrap it toggles `sel`.
  - sel=0 lights units (an=2'b10).
  - sel=1 lights tens (an=2'b01).
- Leading-zero blanking: if tens=0, the tens slot drives all segments off (sseg=7'b1111111) while an still selects it. Units are always shown, so value 0 displays "0".
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- The scan runs continuously and independently of the FSM. The displayed digits change only on the LATCH edge, never mid-conversion.

## Timing
- Reset values (async; apply immediately on rst):
  - FSM in IDLE, busy=0, tens=0, units=0
  - scan counter 0, sel=0
  - an=2'b10, sseg=7'b1000000
- Latency for load sampled at edge k:
  - busy rises after edge k.
  - Shifts occur on edges k+1..k+5.
  - tens/units update and busy falls on edge k+6, so busy is high for exactly 6 cycles.
  - The earliest next accepted load is at edge k+7.
- load held high continuously restarts a conversion every 7 cycles, sampling {co, zi} at each IDLE edge.
- Reset asserted mid-conversion aborts it: tens/units return to 0 and the partial result is discarded.
- The scan toggle period is exactly SCAN_DIV cycles; sel toggles on the edge where the counter wraps from SCAN_DIV-1 to 0.
- {co, zi} need only be stable at the sampling edge. The block does not re-read them during SHIFT.

## Test plan
All scenarios use SCAN_DIV=4, COMMON_ANODE=1.
- Reset: assert rst mid-cycle → asynchronously busy=0, tens=0, units=0, an=2'b10, sseg=7'b1000000. After release, an alternates 10/01 every 4 cycles.
- Max value: co=1, zi=4'hF, one-cycle load:
  - busy high for exactly 6 cycles, then tens=3, units=1.
  - Units phase sseg=1111001; tens phase sseg=0110000.
- Blanking: co=0, zi=9 → tens=0, units=9. Units phase sseg=0010000; tens phase (an=01) sseg=1111111.
- Load while busy: load 16, then at cycle 3 of busy pulse load with co=0, zi=2 → final tens=1, units=6. After busy falls, a new load of 2 gives 0/2.
- Reset mid-conversion: load 25, assert rst after 3 SHIFT cycles → tens=0, units=0, busy=0. Reload 25 → 2/5 after 6 cycles.
- Sweep matching the adder: for all value 0..31, drive {co, zi}=value and load, wait for busy to fall. Check tens=value/10, units=value%10, and sseg of both digits against the code list above.

Source files
------------

// File: rtl/sum_bcd_display_if.sv
// Adder-result display bus: value/strobe in, BCD digits and scanned 7-segment drive out.
// The display stage takes the slave side; the adder or bench takes the master side.
interface sum_bcd_display_if;
  logic       load;
  logic       co;
  logic [3:0] zi;
  logic       busy;
  logic [1:0] tens;
  logic [3:0] units;
  logic [6:0] sseg;
  logic [1:0] an;

  modport master (
    output load, co, zi,
    input  busy, tens, units, sseg, an
  );

  modport slave (
    input  load, co, zi,
    output busy, tens, units, sseg, an
  );
endinterface

// File: rtl/sum_bcd_display.sv
// Converts {co,zi} to two BCD digits by double-dabble and scans them onto a 2-digit 7-seg display.
// Latency: result 6 cycles after the load edge; no backpressure, load is dropped while busy.
module sum_bcd_display #(
  parameter int SCAN_DIV     = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  sum_bcd_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t        state_q, state_d;
  logic [4:0]    bin_q, bin_d;
  logic [5:0]    bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [1:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          sel_q, sel_d;

  logic [3:0]    units_adj;
  logic [10:0]   shifted;
  logic [6:0]    seg_al;
  logic [1:0]    an_al;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    tens_d     = tens_q;
    units_d    = units_q;
    units_adj  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    shifted    = {bcd_q[5:4], units_adj, bin_q};

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d   = {bus.co, bus.zi};
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Tens never reaches 5 for inputs up to 31, so only units is adjusted.
        {bcd_d, bin_d} = {shifted[9:0], 1'b0};
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = LATCH;
      end
      LATCH: begin
        tens_d  = bcd_q[5:4];
        units_d = bcd_q[3:0];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      sel_d      = ~sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      tens_q     <= '0;
      units_q    <= '0;
      scan_cnt_q <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
    end
  end

  // A zero tens digit is blanked but its slot is still enabled in the scan.
  always_comb begin
    if (sel_q) begin
      seg_al = (tens_q == 2'd0) ? 7'b1111111 : seg7({2'b00, tens_q});
      an_al  = 2'b01;
    end else begin
      seg_al = seg7(units_q);
      an_al  = 2'b10;
    end
  end

  assign bus.sseg  = COMMON_ANODE ? seg_al : ~seg_al;
  assign bus.an    = COMMON_ANODE ? an_al  : ~an_al;
  assign bus.busy  = busy_q;
  assign bus.tens  = tens_q;
  assign bus.units = units_q;

endmodule
